fm_read_scheduler: RTL and testbench
====================================

# fm_read_scheduler

Sequencer and output arbiter for the per-layer full-match readers in the track-fit feed. It generates the bunch-crossing framing (`new_bx` pulse, 4-bit `BX_pipe`) that every layer reader consumes. It pops merged full matches from up to four layer readers through their `inRead` handshakes and serialises them onto one ready/valid stream tagged with the layer index. It also reports per-BX match counts and a sticky truncation flag when a BX window closes with data still pending.

## Interface
Parameters:
- `RESDWIDTH`, 40, width of one full-match word.
- `BX_PERIOD`, 150, cycles per BX window including the `new_bx` cycle; legal range 4..1023.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable.
- `new_bx`  out  1  one-cycle BX start pulse to all readers.
- `BX_pipe`  out  4  BX number for the current window, to all readers.
- `fm_in`  in  4*RESDWIDTH  reader outputs; layer i occupies bits [i*RESDWIDTH +: RESDWIDTH].
- `fm_valid`  in  4  reader `valid_o`, one per layer.
- `fm_read`  out  4  reader `inRead`; a pulse pops the current word.
- `out_data`  out  RESDWIDTH+2  {layer[1:0], word}.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `bx_count`  out  7  words emitted during the last completed BX, saturating at 127.
- `trunc`  out  1  sticky: a BX closed with any `fm_valid` high.
- `trunc_clr`  in  1  synchronous clear of `trunc`.

## Operation
FSM states are IDLE, START and RUN.
- IDLE: `new_bx`=0, no pops. When `en`=1, go to START on the next edge.
- START: `new_bx`=1 for exactly one cycle. No pops. Next state is RUN.
- RUN: cycle counter runs 1..BX_PERIOD-1.
  - At BX_PERIOD-1 the FSM goes to START if `en`=1, otherwise to IDLE.
  - Deasserting `en` mid-RUN lets the current window complete.

BX numbering:
- `BX_pipe` holds b during the START cycle and becomes b+1 (mod 16) on the edge ending START.
- The first START after reset therefore presents `BX_pipe`=0.

Arbitration (RUN only; never on the last RUN cycle):
- A slot is free when `out_valid`=0 or `out_ready`=1.
- When a slot is free, the scheduler selects the first layer with `fm_valid` set, searching round-robin from pointer p.
- For the winner g, `fm_read[g]`=1 for that cycle. All other `fm_read` bits are 0.
- On that edge: `out_data` <= {g, fm_in[g]}, `out_valid` <= 1, and p <= g+1 mod 4.
- At most one `fm_read` bit is high in any cycle.

Output register:
- `out_valid` clears on an accept (`out_valid`=1 and `out_ready`=1) with no new load.
- The register is not flushed at START. A held word crosses the window boundary until accepted.

Counting:
- The per-BX count increments on each pop, saturating at 127.
- On the START cycle, `bx_count` <= count and count <= 0.

Truncation:
- On the last RUN cycle, if any `fm_valid`=1, `trunc` <= 1.
- `trunc_clr` has priority over a same-cycle set.

Reset values: state IDLE, `new_bx`=0, `BX_pipe`=0, `fm_read`=0, `out_valid`=0, `out_data`=0, `bx_count`=0, `trunc`=0, p=0, cycle counter 0.

## Timing
- `fm_read` is combinational from `fm_valid`, `out_valid`, `out_ready`, state and p. It has no dependency on `fm_in`.
- Latency is 1 cycle: a word popped in cycle t appears on `out_data` with `out_valid`=1 in cycle t+1.
- Throughput is one word per cycle while `out_ready`=1.
- `new_bx` period is exactly BX_PERIOD cycles while `en`=1.
- The first `new_bx` comes 2 cycles after `en` rises from IDLE: one edge to register `en`, then START.
- Asserting reset mid-window immediately forces all outputs to their reset values. The next window after release starts at BX 0.

## Configuration
- `FM_SCHED_FIXED_PRIO_EN` defined: fixed priority, where the lowest-index valid layer always wins and p is unused.
- Not defined: round-robin as described under Operation.

## Test plan
- Reset release, `en`=1, BX_PERIOD=8 → `new_bx` high on cycles 2, 10, 18; `BX_pipe` reads 0, 1, 2 during those pulses.
- All four `fm_valid`=1, `out_ready`=1 → pops in order 0, 1, 2, 3, 0; `out_data[RESDWIDTH+1:RESDWIDTH]` follows the same order one cycle later.
- Same stimulus with `FM_SCHED_FIXED_PRIO_EN` → every pop goes to layer 0.
- `out_ready`=0 for 3 cycles with a word held → `fm_read`=0 and `out_data` stable; on the release cycle there is one accept plus one new pop.
- Layer 2 holds 5 words, BX_PERIOD=6 → 4 pops, `trunc`=1 after the window, `bx_count`=4 after the next START; `trunc_clr` then returns `trunc` to 0.
- `en` dropped at RUN cycle 2 → the window completes, no further `new_bx`, state IDLE; async reset mid-RUN → `out_valid` and `fm_read` are 0 immediately.

Source files
------------

// File: rtl/fm_read_scheduler.sv
// fm_read_scheduler: BX framing, four-layer full-match pop arbiter and tagged output register.
// Define FM_SCHED_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
module fm_read_scheduler #(
    parameter int RESDWIDTH = 40,
    parameter int BX_PERIOD = 150
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   new_bx,
    output logic [3:0]             BX_pipe,
    input  logic [4*RESDWIDTH-1:0] fm_in,
    input  logic [3:0]             fm_valid,
    output logic [3:0]             fm_read,
    output logic [RESDWIDTH+1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             bx_count,
    output logic                   trunc,
    input  logic                   trunc_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [9:0] BX_LAST = 10'(BX_PERIOD - 1);
    localparam logic [6:0] CNT_MAX = 7'd127;

    state_t     state;
    state_t     state_nxt;
    logic       en_q;
    logic [9:0] cyc;
    logic       last_run;
    logic       slot_free;
    logic       any_valid;
    logic       pop;
    logic [1:0] grant;
    logic [6:0] count;
`ifndef FM_SCHED_FIXED_PRIO_EN
    logic [1:0] rr_ptr;
`endif

    assign last_run  = (state == RUN) && (cyc == BX_LAST);
    assign slot_free = !out_valid || out_ready;
    assign any_valid = |fm_valid;
    // The last RUN cycle never pops, so whatever is still valid there is what gets flagged as truncated.
    assign pop       = (state == RUN) && !last_run && slot_free && any_valid;
    assign fm_read   = pop ? (4'b0001 << grant) : 4'b0000;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        new_bx    = 1'b0;
        case (state)
            IDLE: begin
                if (en_q) state_nxt = START;
            end
            START: begin
                new_bx    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (last_run) state_nxt = en_q ? START : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : arbiter
        logic [1:0] idx;
        grant = 2'd0;
        idx   = 2'd0;
`ifdef FM_SCHED_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            idx = 2'(k);
            if (fm_valid[idx]) grant = idx;
        end
`else
        // Scan from the far end so the candidate closest to rr_ptr is written last and wins.
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (fm_valid[idx]) grant = idx;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            cyc     <= 10'd0;
            BX_pipe <= 4'd0;
        end else begin
            state <= state_nxt;
            en_q  <= en;
            if (state == START) begin
                cyc     <= 10'd1;
                BX_pipe <= BX_pipe + 4'd1;
            end else if (state == RUN) begin
                cyc <= last_run ? 10'd0 : cyc + 10'd1;
            end
        end
    end

    // The output word is deliberately not flushed at START; a held word waits across the boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            out_data  <= {grant, fm_in[int'(grant)*RESDWIDTH +: RESDWIDTH]};
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef FM_SCHED_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 2'd0;
        end else if (pop) begin
            rr_ptr <= grant + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= 7'd0;
            bx_count <= 7'd0;
        end else if (state == START) begin
            bx_count <= count;
            count    <= 7'd0;
        end else if (pop && (count != CNT_MAX)) begin
            count <= count + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trunc <= 1'b0;
        end else if (trunc_clr) begin
            trunc <= 1'b0;
        end else if (last_run && any_valid) begin
            trunc <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fm_read_scheduler.sv
// Self-checking bench for fm_read_scheduler: directed scenarios plus a randomized run
// against a window-phase reference model. Honours FM_SCHED_FIXED_PRIO_EN like the design.
module tb_fm_read_scheduler;

    localparam int W = 40;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic           out_ready = 1'b0;
    logic           trunc_clr = 1'b0;
    logic [4*W-1:0] fm_in;
    logic [3:0]     fm_valid;
    logic           new_bx;
    logic [3:0]     BX_pipe;
    logic [3:0]     fm_read;
    logic [W+1:0]   out_data;
    logic           out_valid;
    logic [6:0]     bx_count;
    logic           trunc;

    int n_cmp = 0;
    int n_bad = 0;

    // Each layer reader is a word queue; front word is presented while non-empty.
    logic [W-1:0] q [4][$];

    always #5 clk = ~clk;

    fm_read_scheduler #(.RESDWIDTH(W), .BX_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .en(en), .new_bx(new_bx), .BX_pipe(BX_pipe),
        .fm_in(fm_in), .fm_valid(fm_valid), .fm_read(fm_read),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bx_count(bx_count), .trunc(trunc), .trunc_clr(trunc_clr)
    );

    function automatic logic [W-1:0] rand_word();
        return {8'($urandom), 32'($urandom)};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            fm_valid[i] = (q[i].size() != 0);
            fm_in[i*W +: W] = (q[i].size() != 0) ? q[i][0] : rand_word();
        end
    endtask

    // Advance one clock: readers pop on the pre-edge fm_read, then return at the next negedge.
    task automatic tick();
        logic [3:0] rd;
        #1;
        rd = fm_read;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (rd[i] && q[i].size() != 0) void'(q[i].pop_front());
        drive_inputs();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        en = 1'b0;
        out_ready = 1'b0;
        trunc_clr = 1'b0;
        drive_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_new_bx(input string tag);
        int n = 0;
        while (new_bx !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (new_bx !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_new_bx_timeout: got=%b exp=1 after %0d cycles", tag, new_bx, n);
        end
    endtask

    function automatic int exp_grant(input int k, input int p);
`ifdef FM_SCHED_FIXED_PRIO_EN
        return 0;
`else
        return (p + k) % 4;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            q[i].push_back(rand_word());
        end
        drive_inputs();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({new_bx, BX_pipe} !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_framing: got new_bx=%b BX_pipe=%0d exp 0/0", new_bx, BX_pipe);
        end
        n_cmp++;
        if (fm_read !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_fm_read: got=%b exp=0000", fm_read);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL reset_out: got valid=%b data=%h exp 0/0", out_valid, out_data);
        end
        n_cmp++;
        if (bx_count !== 7'd0 || trunc !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_status: got bx_count=%0d trunc=%b exp 0/0", bx_count, trunc);
        end
    endtask

    task automatic test_framing();
        logic exp_nb;
        apply_reset();
        en = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            exp_nb = (c == 2 || c == 10 || c == 18);
            n_cmp++;
            if (new_bx !== exp_nb) begin
                n_bad++;
                $display("FAIL framing_new_bx cyc=%0d: got=%b exp=%b", c, new_bx, exp_nb);
            end
            if (exp_nb) begin
                n_cmp++;
                if (BX_pipe !== 4'((c - 2) / P)) begin
                    n_bad++;
                    $display("FAIL framing_bx_pipe cyc=%0d: got=%0d exp=%0d", c, BX_pipe, (c - 2) / P);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int eg;
        logic [W-1:0] pw;
        apply_reset();
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 10; j++) q[i].push_back(rand_word());
        drive_inputs();
        wait_new_bx("rr");
        tick();
        for (int k = 0; k < 5; k++) begin
            eg = exp_grant(k, 0);
            n_cmp++;
            if (fm_read !== 4'(1 << eg)) begin
                n_bad++;
                $display("FAIL rr_fm_read pop=%0d: got=%b exp=%b", k, fm_read, 4'(1 << eg));
            end
            pw = q[eg][0];
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== {2'(eg), pw}) begin
                n_bad++;
                $display("FAIL rr_out pop=%0d: got valid=%b data=%h exp 1/%h", k, out_valid, out_data, {2'(eg), pw});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        apply_reset();
        en = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) q[1].push_back(rand_word());
        drive_inputs();
        wait_new_bx("bp");
        tick();
        n_cmp++;
        if (fm_read !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_first_pop: got=%b exp=0010", fm_read);
        end
        w0 = q[1][0];
        tick();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (fm_read !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_stall_read k=%0d: got=%b exp=0000", k, fm_read);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== {2'd1, w0}) begin
                n_bad++;
                $display("FAIL bp_hold k=%0d: got valid=%b data=%h exp 1/%h", k, out_valid, out_data, {2'd1, w0});
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (fm_read !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_release_pop: got=%b exp=0010", fm_read);
        end
        w1 = q[1][0];
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== {2'd1, w1}) begin
            n_bad++;
            $display("FAIL bp_release_out: got valid=%b data=%h exp 1/%h", out_valid, out_data, {2'd1, w1});
        end
    endtask

    task automatic test_trunc();
        int pops;
        apply_reset();
        en = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) q[2].push_back(rand_word());
        drive_inputs();
        wait_new_bx("trunc");
        tick();
        n_cmp++;
        if (bx_count !== 7'd0) begin
            n_bad++;
            $display("FAIL trunc_first_count: got=%0d exp=0", bx_count);
        end
        pops = 0;
        for (int k = 1; k < P; k++) begin
            if (fm_read !== 4'b0000) pops++;
            tick();
        end
        n_cmp++;
        if (pops != P - 2) begin
            n_bad++;
            $display("FAIL trunc_pops: got=%0d exp=%0d", pops, P - 2);
        end
        n_cmp++;
        if (new_bx !== 1'b1 || trunc !== 1'b1) begin
            n_bad++;
            $display("FAIL trunc_set: got new_bx=%b trunc=%b exp 1/1", new_bx, trunc);
        end
        tick();
        n_cmp++;
        if (bx_count !== 7'(P - 2)) begin
            n_bad++;
            $display("FAIL trunc_bx_count: got=%0d exp=%0d", bx_count, P - 2);
        end
        for (int k = 1; k < P - 1; k++) tick();
        // Last RUN cycle with layer 2 still valid: the clear must win over the set.
        trunc_clr = 1'b1;
        tick();
        trunc_clr = 1'b0;
        n_cmp++;
        if (trunc !== 1'b0) begin
            n_bad++;
            $display("FAIL trunc_clr_priority: got=%b exp=0", trunc);
        end
    endtask

    task automatic test_en_drop();
        int nb;
        logic [3:0] rd_seen;
        apply_reset();
        en = 1'b1;
        wait_new_bx("endrop");
        tick();
        tick();
        en = 1'b0;
        nb = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (new_bx === 1'b1) nb++;
        end
        n_cmp++;
        if (nb != 0) begin
            n_bad++;
            $display("FAIL endrop_new_bx: got=%0d pulses exp=0", nb);
        end
        for (int j = 0; j < 3; j++) q[0].push_back(rand_word());
        out_ready = 1'b1;
        drive_inputs();
        rd_seen = 4'd0;
        for (int k = 0; k < 10; k++) begin
            #1;
            rd_seen = rd_seen | fm_read;
            tick();
        end
        n_cmp++;
        if (rd_seen !== 4'd0) begin
            n_bad++;
            $display("FAIL endrop_idle_reads: got=%b exp=0000", rd_seen);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 10; j++) q[i].push_back(rand_word());
        drive_inputs();
        wait_new_bx("arst");
        repeat (3) tick();
        n_cmp++;
        if (fm_read === 4'd0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_pre_activity: got fm_read=%b out_valid=%b exp nonzero/1", fm_read, out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fm_read !== 4'd0) begin
            n_bad++;
            $display("FAIL arst_immediate: got out_valid=%b fm_read=%b exp 0/0000", out_valid, fm_read);
        end
        n_cmp++;
        if ({new_bx, BX_pipe, bx_count, trunc} !== '0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL arst_outputs: got new_bx=%b BX_pipe=%0d bx_count=%0d trunc=%b data=%h exp all 0",
                     new_bx, BX_pipe, bx_count, trunc, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_new_bx("arst_restart");
        n_cmp++;
        if (BX_pipe !== 4'd0) begin
            n_bad++;
            $display("FAIL arst_restart_bx: got=%0d exp=0", BX_pipe);
        end
    endtask

    // Reference: window phase -1 = idle, 0 = new_bx cycle, 1..P-1 = run cycles.
    task automatic test_random();
        int m_phase, m_bx, m_p, m_cnt, m_bxc, eg, l;
        bit m_en_q, m_ov, m_trunc, anyv;
        logic [W+1:0] m_od;
        logic [3:0] exp_rd;
        apply_reset();
        m_phase = -1; m_bx = 0; m_p = 0; m_cnt = 0; m_bxc = 0;
        m_en_q = 0; m_ov = 0; m_trunc = 0; m_od = '0;
        en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    q[$urandom_range(0, 3)].push_back(rand_word());
            out_ready = ($urandom_range(0, 3) != 0);
            trunc_clr = ($urandom_range(0, 15) == 0);
            drive_inputs();
            #1;
            eg = -1;
            anyv = 0;
            for (int i = 0; i < 4; i++) if (q[i].size() != 0) anyv = 1;
            if (m_phase >= 1 && m_phase <= P - 2 && (!m_ov || out_ready))
                for (int k = 0; k < 4; k++) begin
                    l = exp_grant(k, m_p);
`ifdef FM_SCHED_FIXED_PRIO_EN
                    l = k;
`endif
                    if (eg < 0 && q[l].size() != 0) eg = l;
                end
            exp_rd = (eg >= 0) ? 4'(1 << eg) : 4'd0;
            n_cmp++;
            if (fm_read !== exp_rd) begin
                n_bad++;
                $display("FAIL rand_fm_read cyc=%0d: got=%b exp=%b", c, fm_read, exp_rd);
            end
            n_cmp++;
            if (new_bx !== (m_phase == 0)) begin
                n_bad++;
                $display("FAIL rand_new_bx cyc=%0d: got=%b exp=%b", c, new_bx, m_phase == 0);
            end
            n_cmp++;
            if (BX_pipe !== 4'(m_bx)) begin
                n_bad++;
                $display("FAIL rand_bx_pipe cyc=%0d: got=%0d exp=%0d", c, BX_pipe, m_bx);
            end
            n_cmp++;
            if (out_valid !== m_ov || out_data !== m_od) begin
                n_bad++;
                $display("FAIL rand_out cyc=%0d: got valid=%b data=%h exp %b/%h", c, out_valid, out_data, m_ov, m_od);
            end
            n_cmp++;
            if (bx_count !== 7'(m_bxc) || trunc !== m_trunc) begin
                n_bad++;
                $display("FAIL rand_status cyc=%0d: got bx_count=%0d trunc=%b exp %0d/%b", c, bx_count, trunc, m_bxc, m_trunc);
            end
            if (eg >= 0) begin
                m_od = {2'(eg), q[eg][0]};
                m_ov = 1;
                m_p = (eg + 1) % 4;
                m_cnt = (m_cnt < 127) ? m_cnt + 1 : 127;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (m_phase == P - 1 && anyv) m_trunc = 1;
            if (trunc_clr) m_trunc = 0;
            if (m_phase == 0) begin
                m_bxc = m_cnt;
                m_cnt = 0;
                m_bx = (m_bx + 1) % 16;
            end
            if (m_phase < 0 || m_phase == P - 1) m_phase = m_en_q ? 0 : -1;
            else m_phase++;
            m_en_q = en;
            tick();
        end
        trunc_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_framing();
        test_round_robin();
        test_backpressure();
        test_trunc();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish exp finish");
        $fatal(1, "watchdog");
    end

endmodule
